// File: rtl/complete_arbiter.sv
// Round-robin completion arbiter: picks up to three of NREQ functional-unit results per cycle
// and registers them onto the ROB's three completion ports.
module complete_arbiter #(
    parameter int NREQ = 6,
    parameter int ROBB = 5,
    parameter int XLEN = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               i_squash,
    input  logic [NREQ-1:0]                    i_req_valid,
    input  logic [NREQ-1:0][ROBB-1:0]          i_req_entry,
    input  logic [NREQ-1:0]                    i_req_taken,
    input  logic [NREQ-1:0][XLEN-1:0]          i_req_target,
    output logic [NREQ-1:0]                    o_req_ready,
    output logic [2:0]                         o_complete_valid,
    output logic [2:0][ROBB-1:0]               o_complete_entry,
    output logic [2:0]                         o_precise_state_valid,
    output logic [2:0][XLEN-1:0]               o_target_pc,
    output logic [$clog2(NREQ)-1:0]            o_rr_ptr
);

    localparam int              PW       = $clog2(NREQ);
    localparam logic [PW:0]     NREQ_W   = (PW+1)'(NREQ);
    localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

    logic [PW-1:0]              r_rr_ptr;
    logic [2:0]                 r_valid;
    logic [2:0][ROBB-1:0]       r_entry;
    logic [2:0]                 r_taken;
    logic [2:0][XLEN-1:0]       r_target;

    logic [NREQ-1:0]            w_grant;
    logic [2:0]                 w_slot_valid;
    logic [2:0][ROBB-1:0]       w_slot_entry;
    logic [2:0]                 w_slot_taken;
    logic [2:0][XLEN-1:0]       w_slot_target;
    logic [PW-1:0]              w_last;
    logic [PW-1:0]              w_rr_next;

    // Scan in priority order starting at rr_ptr; the index wraps mod NREQ, not mod 2**PW.
    // Only valid, rr_ptr, squash and reset steer the grants, so req_ready never sees the payload.
    always_comb begin : grant_scan
        logic [PW:0]   v_sum;
        logic [PW-1:0] v_idx;
        logic [1:0]    v_cnt;
        w_grant       = '0;
        w_slot_valid  = '0;
        w_slot_entry  = '0;
        w_slot_taken  = '0;
        w_slot_target = '0;
        w_last        = r_rr_ptr;
        v_sum         = '0;
        v_idx         = '0;
        v_cnt         = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (v_sum >= NREQ_W) begin
                v_sum = v_sum - NREQ_W;
            end
            v_idx = v_sum[PW-1:0];
            if (i_req_valid[v_idx] && (v_cnt != 2'd3) && !i_squash && !reset) begin
                w_grant[v_idx]        = 1'b1;
                w_slot_valid[v_cnt]   = 1'b1;
                w_slot_entry[v_cnt]   = i_req_entry[v_idx];
                w_slot_taken[v_cnt]   = i_req_taken[v_idx];
                w_slot_target[v_cnt]  = i_req_target[v_idx];
                w_last                = v_idx;
                v_cnt                 = v_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        w_rr_next = r_rr_ptr;
        if (|w_grant) begin
            w_rr_next = (w_last == LAST_IDX) ? '0 : w_last + PW'(1);
        end
    end

    // Squash empties the output stage on the next edge; a completion already registered still shows this cycle.
    always_ff @(posedge clock) begin
        if (reset || i_squash) begin
            r_rr_ptr <= '0;
            r_valid  <= '0;
            r_entry  <= '0;
            r_taken  <= '0;
            r_target <= '0;
        end else begin
            r_rr_ptr <= w_rr_next;
            r_valid  <= w_slot_valid;
            r_entry  <= w_slot_entry;
            r_taken  <= w_slot_taken;
            r_target <= w_slot_target;
        end
    end

    assign o_req_ready           = w_grant;
    assign o_complete_valid      = r_valid;
    assign o_complete_entry      = r_entry;
    assign o_precise_state_valid = r_taken;
    assign o_target_pc           = r_target;
    assign o_rr_ptr              = r_rr_ptr;

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter (NREQ=6): hand-computed grants, slot contents and rr_ptr.
module tb_complete_arbiter;

    logic                 clock;
    logic                 reset;
    logic                 squash;
    logic [5:0]           req_valid;
    logic [5:0][4:0]      req_entry;
    logic [5:0]           req_taken;
    logic [5:0][31:0]     req_target;
    logic [5:0]           req_ready;
    logic [2:0]           complete_valid;
    logic [2:0][4:0]      complete_entry;
    logic [2:0]           precise_state_valid;
    logic [2:0][31:0]     target_pc;
    logic [2:0]           rr_ptr;

    int n_vec  = 0;
    int n_miss = 0;
    logic [4:0] exp_q[$];

    complete_arbiter #(.NREQ(6), .ROBB(5), .XLEN(32)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .i_squash              (squash),
        .i_req_valid           (req_valid),
        .i_req_entry           (req_entry),
        .i_req_taken           (req_taken),
        .i_req_target          (req_target),
        .o_req_ready           (req_ready),
        .o_complete_valid      (complete_valid),
        .o_complete_entry      (complete_entry),
        .o_precise_state_valid (precise_state_valid),
        .o_target_pc           (target_pc),
        .o_rr_ptr              (rr_ptr)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Two requesters naming the same ROB entry in one cycle is illegal stimulus.
    always @(negedge clock) begin
        int dup;
        dup = 0;
        for (int a = 0; a < 6; a++)
            for (int b = a + 1; b < 6; b++)
                if (req_valid[a] && req_valid[b] && req_entry[a] == req_entry[b]) dup++;
        if (dup != 0) check("dup_entry", 32'(dup), 32'd0);
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input logic [4:0] e, input logic tk, input logic [31:0] tg);
        req_valid[i]  = 1'b1;
        req_entry[i]  = e;
        req_taken[i]  = tk;
        req_target[i] = tg;
    endtask

    task automatic drop(input int i);
        req_valid[i]  = 1'b0;
        req_entry[i]  = '0;
        req_taken[i]  = 1'b0;
        req_target[i] = '0;
    endtask

    task automatic drop_all();
        for (int i = 0; i < 6; i++) drop(i);
    endtask

    task automatic check_ready(input string tag, input logic [5:0] exp);
        #1;
        check(tag, 32'(req_ready), 32'(exp));
    endtask

    task automatic check_out(input string tag, input logic [2:0] v, input logic [4:0] e0,
                             input logic [4:0] e1, input logic [4:0] e2, input logic [2:0] rr);
        check({tag, "_valid"}, 32'(complete_valid), 32'(v));
        check({tag, "_e0"},    32'(complete_entry[0]), 32'(e0));
        check({tag, "_e1"},    32'(complete_entry[1]), 32'(e1));
        check({tag, "_e2"},    32'(complete_entry[2]), 32'(e2));
        check({tag, "_rr"},    32'(rr_ptr), 32'(rr));
    endtask

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        drop_all();
        req_valid = 6'b111111;

        // 1: reset blocks grants and clears state; idle cycles stay empty
        tick();
        check_ready("t1_rst_ready", 6'b000000);
        check_out("t1_rst", 3'b000, 5'd0, 5'd0, 5'd0, 3'd0);
        check("t1_rst_tpc0", target_pc[0], 32'd0);
        check("t1_rst_psv", 32'(precise_state_valid), 32'd0);
        reset = 1'b0;
        drop_all();
        for (int c = 0; c < int'($urandom_range(2, 4)); c++) begin
            check_ready("t1_idle_ready", 6'b000000);
            tick();
            check_out("t1_idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'd0);
        end

        // 2: two requesters from rr_ptr=0
        drive(0, 5'd4, 1'b0, 32'h0);
        drive(2, 5'd9, 1'b0, 32'h0);
        check_ready("t2_ready", 6'b000101);
        tick();
        check_out("t2", 3'b011, 5'd4, 5'd9, 5'd0, 3'd3);
        drop_all();
        tick();
        check_out("t2_idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'd3);

        // bring rr_ptr back to 0 with a lone squash pulse
        squash = 1'b1;
        tick();
        squash = 1'b0;
        check("sq_rr", 32'(rr_ptr), 32'd0);

        // 3: all six valid for two cycles
        for (int i = 0; i < 6; i++) begin
            drive(i, 5'(10 + i), 1'b0, 32'h100 * i);
            exp_q.push_back(5'(10 + i));
        end
        check_ready("t3_c1_ready", 6'b000111);
        tick();
        check("t3_c1_valid", 32'(complete_valid), 32'h7);
        check("t3_c1_rr", 32'(rr_ptr), 32'd3);
        for (int s = 0; s < 3; s++) check($sformatf("t3_c1_slot%0d", s), 32'(complete_entry[s]), 32'(exp_q.pop_front()));
        check("t3_c1_tpc2", target_pc[2], 32'h200);
        check_ready("t3_c2_ready", 6'b111000);
        tick();
        check("t3_c2_valid", 32'(complete_valid), 32'h7);
        check("t3_c2_rr", 32'(rr_ptr), 32'd0);
        for (int s = 0; s < 3; s++) check($sformatf("t3_c2_slot%0d", s), 32'(complete_entry[s]), 32'(exp_q.pop_front()));
        check("t3_c2_tpc2", target_pc[2], 32'h500);
        drop_all();

        // 4: move rr_ptr to 4, then wrap-around scan with a stalled requester
        drive(3, 5'd20, 1'b0, 32'h0);
        check_ready("t4_pre_ready", 6'b001000);
        tick();
        check_out("t4_pre", 3'b001, 5'd20, 5'd0, 5'd0, 3'd4);
        drive(5, 5'd25, 1'b0, 32'h0);
        drive(0, 5'd26, 1'b0, 32'h0);
        drive(1, 5'd27, 1'b0, 32'h0);
        drive(3, 5'd21, 1'b0, 32'h0);
        check_ready("t4_ready", 6'b100011);
        tick();
        check_out("t4_wrap", 3'b111, 5'd25, 5'd26, 5'd27, 3'd2);
        drop(5); drop(0); drop(1);
        check_ready("t4_stall_ready", 6'b001000);
        tick();
        check_out("t4_stall", 3'b001, 5'd21, 5'd0, 5'd0, 3'd4);
        drop_all();

        // 5: branch result carries taken and target
        drive(4, 5'd7, 1'b1, 32'h0000_1040);
        drive(2, 5'd8, 1'b0, 32'h0);
        check_ready("t5_ready", 6'b010100);
        tick();
        check_out("t5", 3'b011, 5'd7, 5'd8, 5'd0, 3'd3);
        check("t5_psv", 32'(precise_state_valid), 32'b001);
        check("t5_tpc0", target_pc[0], 32'h0000_1040);
        check("t5_tpc1", target_pc[1], 32'h0);
        drop_all();

        // 6: squash with four valid; the completion registered last cycle is still visible
        drive(0, 5'd1, 1'b0, 32'h0);
        drive(1, 5'd2, 1'b0, 32'h0);
        drive(2, 5'd3, 1'b0, 32'h0);
        drive(3, 5'd5, 1'b0, 32'h0);
        squash = 1'b1;
        check_ready("t6_sq_ready", 6'b000000);
        check("t6_sq_prev_valid", 32'(complete_valid), 32'b011);
        tick();
        squash = 1'b0;
        check_out("t6_sq", 3'b000, 5'd0, 5'd0, 5'd0, 3'd0);
        check_ready("t6_resume_ready", 6'b000111);
        tick();
        check_out("t6_resume", 3'b111, 5'd1, 5'd2, 5'd3, 3'd3);
        drop(0); drop(1); drop(2);
        check_ready("t6_tail_ready", 6'b001000);
        tick();
        check_out("t6_tail", 3'b001, 5'd5, 5'd0, 5'd0, 3'd4);
        drop_all();
        tick();
        check_out("t6_idle", 3'b000, 5'd0, 5'd0, 5'd0, 3'd4);

        // reset wins over squash and blocks grants
        drive(4, 5'd11, 1'b0, 32'h0);
        reset  = 1'b1;
        squash = 1'b1;
        check_ready("rst_sq_ready", 6'b000000);
        tick();
        check_out("rst_sq", 3'b000, 5'd0, 5'd0, 5'd0, 3'd0);
        reset  = 1'b0;
        squash = 1'b0;
        drop_all();
        tick();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
